// File: rtl/issue_pkg.sv
// Shared definitions for the instruction issue unit.
// Instruction field positions, the NOP word and the RAW hazard compare.
// Pure definitions; no state, no latency, no flow control.
package issue_pkg;

  localparam int ALUOP_HI = 31;
  localparam int ALUOP_LO = 29;
  localparam int WE_BIT   = 28;
  localparam int DS_BIT   = 27;
  localparam int WS_HI    = 26;
  localparam int WS_LO    = 22;
  localparam int RS1_HI   = 21;
  localparam int RS1_LO   = 17;
  localparam int RS2_HI   = 16;
  localparam int RS2_LO   = 12;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // True when producer p writes a register that candidate c reads.
  // RS2 overlaps the immediate, so it only counts when c uses a register operand.
  // Register 0 is treated like any other register.
  function automatic logic hazard(input logic [31:0] p, input logic [31:0] c);
    logic rs1_hit;
    logic rs2_hit;
    rs1_hit = (p[WS_HI:WS_LO] == c[RS1_HI:RS1_LO]);
    rs2_hit = !c[DS_BIT] && (p[WS_HI:WS_LO] == c[RS2_HI:RS2_LO]);
    return p[WE_BIT] && (rs1_hit || rs2_hit);
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Generic synchronous FIFO holding instruction words.
// Latency: a word written at one edge is visible at head after that edge.
// Backpressure: push ignored when full, pop ignored when empty.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset since level gates their use.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH; occupancy tracked by an explicit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/instr_issue_unit.sv
// Buffers instructions and issues one word per clock, inserting NOPs on RAW hazards.
// Latency: a word pushed at edge k issues at edge k+1 at the earliest.
// Backpressure: in_ready = !full; a same-cycle pop frees space only after the edge.
module instr_issue_unit
  import issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [31:0]            in_instr,
  output logic                   in_ready,
  output logic [31:0]            InstrOut,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       bubble_count
);

  logic [31:0] h2;
  logic [31:0] cand;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        stall;

  assign in_ready = !full;
  assign push     = in_valid && !full;

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (in_instr),
    .pop   (pop),
    .head  (cand),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  // Head must wait while either of the last two issued words still writes a source.
  always_comb begin
    stall = !empty && (hazard(InstrOut, cand) || hazard(h2, cand));
    pop   = !empty && !stall;
  end

  // Issue register, two-deep history and saturating hazard-bubble counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrOut     <= NOP;
      h2           <= NOP;
      bubble_count <= '0;
    end else begin
      InstrOut <= pop ? cand : NOP;
      h2       <= InstrOut;
      if (stall && (bubble_count != '1)) bubble_count <= bubble_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed bench for instr_issue_unit with hand-computed issue sequences.
// Inputs driven 1ns after the rising edge; outputs sampled at the same point.
// Producer side retries a word until it is accepted.
module tb_instr_issue_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_ready;
  logic [31:0] InstrOut;
  logic [2:0]  fifo_level;
  logic [15:0] bubble_count;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] pushq[$];
  logic [31:0] outq[$];
  logic [31:0] expq[$];
  int          max_lvl;
  logic        saw_not_ready;

  logic [31:0] a, b, x, f;
  logic [31:0] w[6];

  instr_issue_unit #(.DEPTH(4), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_ready     (in_ready),
    .InstrOut     (InstrOut),
    .fifo_level   (fifo_level),
    .bubble_count (bubble_count)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic we, input logic ds, input logic [4:0] ws,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    logic [31:0] r;
    r = 32'h0;
    r[31:29] = 3'b001;
    r[28]    = we;
    r[27]    = ds;
    r[26:22] = ws;
    r[21:17] = rs1;
    r[16:12] = rs2;
    return r;
  endfunction

  // Run n cycles, feeding pushq and recording InstrOut after each edge.
  task automatic run(input int n);
    logic rdy;
    for (int i = 0; i < n; i++) begin
      in_valid = (pushq.size() > 0);
      in_instr = (pushq.size() > 0) ? pushq[0] : 32'h0;
      rdy = in_ready;
      if (!rdy) saw_not_ready = 1'b1;
      @(posedge clk);
      #1;
      if (in_valid && rdy) void'(pushq.pop_front());
      outq.push_back(InstrOut);
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
    end
    in_valid = 1'b0;
  endtask

  task automatic cmp_seq(input string tag);
    check_vec({tag, "_len"}, 32'(outq.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < outq.size(); i++)
      check_vec($sformatf("%s_slot%0d", tag, i), outq[i], expq[i]);
    outq.delete();
    expq.delete();
  endtask

  initial begin
    max_lvl = 0;
    saw_not_ready = 1'b0;
    #2;
    check_vec("rst_instr", InstrOut, 32'h0);
    check_vec("rst_level", 32'(fifo_level), 32'd0);
    check_vec("rst_bubble", 32'(bubble_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_vec("rst_ready", 32'(in_ready), 32'd1);

    // 1: independent stream, back to back
    for (int i = 0; i < 4; i++) begin
      w[i] = mk(1'b1, 1'b0, 5'(i + 1), 5'd10, 5'd11);
      pushq.push_back(w[i]);
    end
    run(6);
    expq = '{32'h0, w[0], w[1], w[2], w[3], 32'h0};
    cmp_seq("indep");
    check_vec("indep_bubble", 32'(bubble_count), 32'd0);

    // 2: adjacent RAW
    a = mk(1'b1, 1'b0, 5'd5, 5'd20, 5'd21);
    b = mk(1'b1, 1'b0, 5'd6, 5'd5, 5'd21);
    pushq = '{a, b};
    run(6);
    expq = '{32'h0, a, 32'h0, 32'h0, b, 32'h0};
    cmp_seq("raw1");
    check_vec("raw1_bubble", 32'(bubble_count), 32'd2);

    // 3: distance-2 RAW through RS2
    x = mk(1'b1, 1'b0, 5'd7, 5'd20, 5'd21);
    b = mk(1'b1, 1'b0, 5'd8, 5'd20, 5'd5);
    pushq = '{a, x, b};
    run(6);
    expq = '{32'h0, a, x, 32'h0, b, 32'h0};
    cmp_seq("raw2");
    check_vec("raw2_bubble", 32'(bubble_count), 32'd3);

    // 4a: immediate bits equal to WS are not a source
    b = mk(1'b1, 1'b1, 5'd9, 5'd20, 5'd5);
    pushq = '{a, b};
    run(5);
    expq = '{32'h0, a, b, 32'h0, 32'h0};
    cmp_seq("imm");
    check_vec("imm_bubble", 32'(bubble_count), 32'd3);

    // 4b: producer without write enable is not a hazard
    a = mk(1'b0, 1'b0, 5'd5, 5'd20, 5'd21);
    b = mk(1'b1, 1'b0, 5'd9, 5'd5, 5'd21);
    pushq = '{a, b};
    run(5);
    expq = '{32'h0, a, b, 32'h0, 32'h0};
    cmp_seq("nowe");
    check_vec("nowe_bubble", 32'(bubble_count), 32'd3);

    // 5: dependent chain of six with backpressure
    for (int i = 0; i < 6; i++) begin
      w[i] = mk(1'b1, 1'b0, 5'(i + 2), (i == 0) ? 5'd30 : 5'(i + 1), 5'd31);
      pushq.push_back(w[i]);
    end
    max_lvl = 0;
    saw_not_ready = 1'b0;
    run(19);
    expq.push_back(32'h0);
    for (int i = 0; i < 6; i++) begin
      expq.push_back(w[i]);
      expq.push_back(32'h0);
      expq.push_back(32'h0);
    end
    cmp_seq("chain");
    check_vec("chain_bubble", 32'(bubble_count), 32'd13);
    check_vec("chain_maxlvl", 32'(max_lvl), 32'd4);
    check_vec("chain_backpressure", 32'(saw_not_ready), 32'd1);
    check_vec("chain_drained", 32'(fifo_level), 32'd0);

    // 6: async reset mid-stream with three words buffered
    a = mk(1'b1, 1'b0, 5'd12, 5'd20, 5'd21);
    b = mk(1'b1, 1'b0, 5'd13, 5'd12, 5'd21);
    x = mk(1'b1, 1'b0, 5'd14, 5'd13, 5'd21);
    pushq = '{a, b, x, x, x};
    run(5);
    outq.delete();
    check_vec("pre_rst_level", 32'(fifo_level), 32'd3);
    check_vec("pre_rst_instr", InstrOut, b);
    #2;
    rst = 1'b1;
    #1;
    check_vec("mid_rst_instr", InstrOut, 32'h0);
    check_vec("mid_rst_level", 32'(fifo_level), 32'd0);
    check_vec("mid_rst_bubble", 32'(bubble_count), 32'd0);
    check_vec("mid_rst_ready", 32'(in_ready), 32'd1);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_vec("post_rst_instr", InstrOut, 32'h0);
    f = mk(1'b1, 1'b0, 5'd15, 5'd13, 5'd12);
    pushq = '{f};
    run(3);
    expq = '{32'h0, f, 32'h0};
    cmp_seq("post_rst");
    check_vec("post_rst_bubble", 32'(bubble_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no completion, expected finish before 50000ns");
    $fatal(1);
  end

endmodule
